// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC generator plus DEPTH-entry instruction FIFO; define IFQ_BYPASS_EN for a same-cycle empty-queue bypass
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_en,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [31:0]   pc_q;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          q_valid, pop, push, byp, byp_take;
  assign q_valid = cnt != '0;
  assign pop     = q_valid && out_ready;
`ifdef IFQ_BYPASS_EN
  assign byp      = rst && !q_valid && !redirect_en;
  assign byp_take = byp && out_ready;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif
  assign push      = !redirect_en && !byp_take && (cnt < FULL || pop);
  assign imem_addr = pc_q;
  assign count     = cnt;
  assign out_valid = q_valid || byp;
  assign out_instr = q_valid ? instr_mem[rd_ptr] : imem_rdata;
  assign out_pc    = q_valid ? pc_mem[rd_ptr] : pc_q;
  // FIFO storage: write the fetched word and its address at the tail
  always_ff @(posedge clk)
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= pc_q;
    end
  // Control: fetch PC, pointers and occupancy; redirect flushes and reloads
  always_ff @(posedge clk)
    if (!rst) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      pc_q   <= redirect_en ? (redirect_pc & 32'hFFFF_FFFC) : pc_q + ((push || byp_take) ? 32'd4 : 32'd0);
      rd_ptr <= redirect_en ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= redirect_en ? '0 : wr_ptr + AW'(push);
      cnt    <= redirect_en ? '0 : cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low; ports named clk and rst.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of queue entries (power of two, 2..16).
REQ-003 Parameter RESET_PC, default 32'h0000_0000, SHALL set the fetch address loaded at reset (word-aligned).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 imem_addr  output  32  fetch PC driven to the asynchronous instruction ROM.
REQ-007 imem_rdata  input  32  ROM data for imem_addr, valid in the same cycle.
REQ-008 redirect_en  input  1  branch/jump taken; flushes the queue and reloads the PC.
REQ-009 redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored and treated as 0.
REQ-010 out_valid  output  1  head entry is valid toward the IF/ID register.
REQ-011 out_instr  output  32  head instruction word.
REQ-012 out_pc  output  32  address of the head instruction.
REQ-013 out_ready  input  1  consumer accepts the head this cycle (driven by pipeline_advance).
REQ-014 count  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-015 Pop SHALL occur when out_valid && out_ready; the head advances on the next rising edge.
REQ-016 Push SHALL occur when !redirect_en && (count < DEPTH || pop); it stores {imem_addr, imem_rdata} at the tail, and the fetch PC becomes fetch PC + 4.
REQ-017 When no push occurs, the fetch PC SHALL hold.
REQ-018 Fetch PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-019 Push and pop in the same cycle while full SHALL leave count at DEPTH.
REQ-020 Push and pop in the same cycle while partially full SHALL leave count unchanged.
REQ-021 Pop while empty SHALL be impossible, because out_valid is 0.
REQ-022 Redirect cycle behaviour SHALL be:
- a pop in that cycle is honoured (the consumer keeps that entry);
- all remaining entries are discarded; count = 0 next cycle;
- fetch PC = {redirect_pc[31:2], 2'b00} next cycle;
- no push occurs.
REQ-023 Redirect SHALL take precedence over push.
REQ-024 Back-to-back redirects SHALL each reload the PC; the last one wins.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 out_valid SHALL equal (count != 0); out_instr and out_pc SHALL show the head entry, with don't-care values when empty.
REQ-027 Default latency (macro undefined) SHALL be: an instruction fetched in cycle N appears at the head no earlier than cycle N+1.
REQ-028 Steady state with out_ready held 1 SHALL deliver one instruction per cycle.

Reset
REQ-029 While rst=0 at a rising edge, the block SHALL set fetch PC = RESET_PC, pointers = 0, count = 0.
REQ-030 Outputs during reset SHALL be out_valid = 0 and count = 0; imem_addr = RESET_PC from the cycle after the reset edge.
REQ-031 Reset asserted mid-operation SHALL discard all entries; no push or pop takes effect in that cycle.
REQ-032 In the first cycle after rst returns to 1, the block SHALL push RESET_PC's instruction; out_valid = 1 in the following cycle.

Configuration
REQ-033 The macro IFQ_BYPASS_EN SHALL control a same-cycle bypass.
REQ-034 With IFQ_BYPASS_EN defined, when count == 0 && !redirect_en, the block SHALL drive:
- out_valid = 1;
- out_instr = imem_rdata;
- out_pc = imem_addr.
If out_ready = 1 in that case, the word is consumed directly, not pushed, and the PC still advances by 4.
REQ-035 Without IFQ_BYPASS_EN, no bypass path SHALL exist and REQ-027 applies.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Reset: rst=0 two cycles, then 1, ROM[0]=32'h00000013, out_ready=1 -> out_valid=1 with out_pc=0, out_instr=32'h00000013 one cycle after release; then out_pc = 4, 8, 12 on consecutive cycles.
- Fill/backpressure: out_ready=0 for 6 cycles, DEPTH=4 -> count reaches 4 and stays 4; imem_addr holds 16; out_ready=1 -> out_pc sequence 0, 4, 8, 12, 16 with no gaps.
- Redirect: count=3, redirect_en=1 with redirect_pc=32'h40 and out_ready=1 -> head at pc 0 consumed; next cycle count=0 and imem_addr=32'h40; first out_pc after that = 32'h40.
- Misaligned redirect: redirect_pc=32'h47 -> imem_addr=32'h44.
- Wrap and mid-run reset: RESET_PC=32'hFFFFFFF8 -> out_pc FFFFFFF8, FFFFFFFC, 00000000; rst=0 with count=2 -> next cycle count=0, out_valid=0.
- IFQ_BYPASS_EN defined: after reset, out_ready=1 -> out_valid=1 and out_pc=RESET_PC in the first cycle after release; count stays 0.
